// File: rtl/zap_wb_ram_responder.sv
// Wishbone B4 registered-feedback RAM responder for the ZAP bus master.
// Handshake: a beat completes on any rising edge where (o_wb_ack|o_wb_err) & i_wb_cyc & i_wb_stb.
module zap_wb_ram_responder #(
    parameter logic [31:0] DEPTH       = 32'd1024,
    parameter logic [31:0] WAIT_STATES = 32'd1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic [2:0]  i_wb_cti,
    input  logic [1:0]  i_wb_bte,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [31:0] o_wb_dat,
    output logic [1:0]  o_dbg_state
);

    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] LP_WS = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ACK   = 2'd2,
        S_STALL = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [29:0] r_beat_adr;
    logic [29:0] w_adr_nxt;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;
    logic        w_load;
    logic        w_req;
    logic        w_commit;
    logic        w_bad_burst;
    logic        w_out_of_range;
    logic        w_err_nxt;
    logic [31:0] w_rd_word;
    logic [31:0] w_dat_nxt;
    logic        w_unused_adr_lsb;

    logic [31:0] r_mem [0:DEPTH-1];

    assign w_req            = i_wb_cyc & i_wb_stb;
    assign w_commit         = r_ack & w_req & i_wb_we;
    assign w_bad_burst      = (i_wb_cti == 3'b010) && (i_wb_bte != 2'b00);
    assign w_out_of_range   = ({2'b00, w_adr_nxt} >= DEPTH);
    assign w_err_nxt        = w_out_of_range | w_bad_burst;
    assign w_rd_word        = r_mem[w_adr_nxt[AW-1:0]];
    assign w_dat_nxt        = w_err_nxt ? 32'd0 : w_rd_word;
    assign w_unused_adr_lsb = ^i_wb_adr[1:0];

    // w_load marks the cycle before a beat is presented on ack/err, whether new or re-presented.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_adr_nxt   = r_beat_adr;
        w_load      = 1'b0;
        if (!i_wb_cyc) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_wb_stb) begin
                        w_adr_nxt = i_wb_adr[31:2];
                        w_cnt_nxt = LP_WS;
                        if (LP_WS == 4'd0) begin
                            w_state_nxt = S_ACK;
                            w_load      = 1'b1;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    w_cnt_nxt = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = S_ACK;
                        w_load      = 1'b1;
                    end
                end
                S_ACK: begin
                    if (!i_wb_stb) begin
                        w_state_nxt = S_STALL;
                    end else if (r_ack && (i_wb_cti == 3'b010)) begin
                        w_adr_nxt = r_beat_adr + 30'd1;
                        w_load    = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_STALL: begin
                    if (i_wb_stb) begin
                        w_state_nxt = S_ACK;
                        w_load      = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_beat_adr <= 30'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_beat_adr <= w_adr_nxt;
            r_ack      <= w_load & ~w_err_nxt;
            r_err      <= w_load & w_err_nxt;
            r_dat      <= w_load ? w_dat_nxt : 32'd0;
        end
    end

    // The array keeps its contents through reset; r_ack is cleared by reset so no write can slip through.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) begin
                    r_mem[r_beat_adr[AW-1:0]][8*b +: 8] <= i_wb_dat[8*b +: 8];
                end
            end
        end
    end

    assign o_wb_ack    = r_ack;
    assign o_wb_err    = r_err;
    assign o_wb_dat    = r_dat;
    assign o_dbg_state = r_state;

endmodule
